// File: rtl/aes_inv_shiftrow_pipe_if.sv
// rtl/aes_inv_shiftrow_pipe_if.sv - input/output stream handshake bundle for the InvShiftRows pipe
interface aes_inv_shiftrow_pipe_if;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;

  // Pipe side: consumes the input stream, produces the output stream
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Driver/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_shiftrow_pipe.sv
// rtl/aes_inv_shiftrow_pipe.sv - AES InvShiftRows with a 1- or 2-entry output FIFO
module aes_inv_shiftrow_pipe #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  aes_inv_shiftrow_pipe_if.slave  s,
  output logic                    busy,
  output logic [CNT_W-1:0]        blk_cnt
);

  if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
    $error("aes_inv_shiftrow_pipe: DEPTH must be 1 or 2");
  end

  logic [127:0]     mem_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             run_q;     // holds in_ready low until the first edge after reset
  logic             acc_fire;
  logic             rel_fire;

  // Row r of the state rotates right by r columns: out[r][c] = in[r][(c-r) mod 4]
  function automatic logic [127:0] inv_shift(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return y;
  endfunction

  // Pointers wrap at DEPTH; with DEPTH=1 they stay at zero
  function automatic logic ptr_inc(input logic p);
    return (p == 1'(DEPTH-1)) ? 1'b0 : ~p;
  endfunction

  assign s.in_ready  = run_q && (count_q < 2'(DEPTH));
  assign s.out_valid = (count_q != 2'd0);
  assign s.out_data  = mem_q[rd_ptr_q];
  assign busy        = (count_q != 2'd0);
  assign blk_cnt     = blk_cnt_q;

  assign acc_fire = s.in_valid && s.in_ready;
  assign rel_fire = s.out_valid && s.out_ready;

  // Next-state for occupancy tracking; flush overrides any same-cycle accept/release
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    blk_cnt_d = blk_cnt_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (acc_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rel_fire) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
      count_d = count_q + {1'b0, acc_fire} - {1'b0, rel_fire};
    end
  end

  // Occupancy, pointers, transfer counter and ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      blk_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_cnt_q <= blk_cnt_d;
      run_q     <= 1'b1;
    end
  end

  // Entry storage holds already-permuted data; flush leaves contents in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (acc_fire && !flush) begin
      mem_q[wr_ptr_q] <= inv_shift(s.in_data);
    end
  end

endmodule

// File: tb/tb_aes_inv_shiftrow_pipe.sv
// tb/tb_aes_inv_shiftrow_pipe.sv - randomized self-checking bench for aes_inv_shiftrow_pipe
module tb_aes_inv_shiftrow_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        flush2 = 1'b0;
  logic        busy, busy2;
  logic [15:0] blk_cnt;
  logic [3:0]  blk_cnt2;

  aes_inv_shiftrow_pipe_if bus();
  aes_inv_shiftrow_pipe_if bus2();

  always #5 clk = ~clk;

  aes_inv_shiftrow_pipe #(.CNT_W(16), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(bus.slave),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  aes_inv_shiftrow_pipe #(.CNT_W(4), .DEPTH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .s(bus2.slave),
    .busy(busy2), .blk_cnt(blk_cnt2)
  );

  int           n_checks = 0;
  int           n_pass = 0;
  int           n_rt = 0;
  int           n_acc = 0;
  logic [127:0] q_exp[$];
  logic [127:0] q_orig[$];
  logic [127:0] q2[$];
  logic [15:0]  blk_model = '0;

  // out byte k takes in byte SRC[k]
  int unsigned src_tab [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [127:0] inv_ref(input logic [127:0] v);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = v[127-8*src_tab[k] -: 8];
    return y;
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] v);
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*c+r) -: 8] = v[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock of the main DUT checked against the queue model
  task automatic step();
    logic acc, rel;
    @(negedge clk);
    chk("out_valid", bus.out_valid, q_exp.size() != 0);
    chk("in_ready", bus.in_ready, q_exp.size() < 2);
    chk("busy", busy, q_exp.size() != 0);
    if (q_exp.size() != 0) chk("out_data", bus.out_data, q_exp[0]);
    acc = bus.in_valid && (q_exp.size() < 2);
    rel = (q_exp.size() != 0) && bus.out_ready;
    if (flush) begin
      q_exp.delete();
      q_orig.delete();
    end else begin
      if (rel) begin
        chk("round_trip", fwd_ref(bus.out_data), q_orig[0]);
        n_rt++;
        void'(q_exp.pop_front());
        void'(q_orig.pop_front());
        blk_model++;
      end
      if (acc) begin
        q_exp.push_back(inv_ref(bus.in_data));
        q_orig.push_back(bus.in_data);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    chk("blk_cnt", blk_cnt, blk_model);
  endtask

  initial begin
    logic [127:0] a, b, c;
    logic [15:0]  base;
    logic         all_ready;
    int           s_acc, s_rel;
    logic         s_acc_now, s_rel_now;

    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_out_data", bus.out_data, 128'h0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", bus.in_ready, 1);

    // Single transfer with the reference vector
    bus.in_valid = 1; bus.out_ready = 1;
    bus.in_data = 128'h000102030405060708090a0b0c0d0e0f;
    step();
    bus.in_valid = 0;
    chk("single_valid", bus.out_valid, 1);
    chk("single_data", bus.out_data, 128'h000d0a0704010e0b0805020f0c090603);
    step();
    chk("single_blk", blk_cnt, 16'd1);

    // Random traffic with random backpressure, round-trip checked
    for (int i = 0; i < 6000 && n_acc < 1001; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = rnd128();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.in_valid = 0; bus.out_ready = 1;
    for (int i = 0; i < 4 && q_exp.size() != 0; i++) step();
    chk("rt_enough", n_rt >= 1000, 1);

    // Backpressure: A, B accepted, C refused, inv(A) held
    a = rnd128(); b = rnd128(); c = rnd128();
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_data = a; step();
    bus.in_data = b; step();
    bus.in_data = c;
    chk("bp_ready_low", bus.in_ready, 0);
    chk("bp_hold", bus.out_data, inv_ref(a));
    step();
    chk("bp_hold2", bus.out_data, inv_ref(a));
    bus.in_valid = 0; bus.out_ready = 1;
    step();
    chk("bp_second", bus.out_data, inv_ref(b));
    step();
    chk("bp_empty", bus.out_valid, 0);

    // Full throughput: 100 back-to-back transfers
    base = blk_model;
    all_ready = 1'b1;
    bus.in_valid = 1; bus.out_ready = 1;
    for (int i = 0; i < 100; i++) begin
      bus.in_data = rnd128();
      #1 all_ready = all_ready & bus.in_ready;
      step();
    end
    bus.in_valid = 0;
    step();
    chk("tput_ready", all_ready, 1);
    chk("tput_blk", blk_cnt, base + 16'd100);

    // Flush with buffer full plus presented input
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_data = rnd128(); step();
    bus.in_data = rnd128(); step();
    base = blk_cnt;
    flush = 1; bus.in_data = rnd128(); bus.out_ready = 1;
    step();
    flush = 0; bus.in_valid = 0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_blk", blk_cnt, base);

    // Flush with one entry and simultaneous accept and release
    bus.in_valid = 1; bus.out_ready = 0; bus.in_data = rnd128(); step();
    flush = 1; bus.out_ready = 1; bus.in_data = rnd128();
    step();
    flush = 0; bus.in_valid = 0;
    chk("flush2_valid", bus.out_valid, 0);
    chk("flush2_blk", blk_cnt, base);
    step();

    // Async reset between edges with two entries buffered
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_data = rnd128(); step();
    bus.in_data = rnd128(); step();
    bus.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_blk", blk_cnt, 0);
    chk("arst_ready", bus.in_ready, 0);
    q_exp.delete(); q_orig.delete(); blk_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready_back", bus.in_ready, 1);
    bus.out_ready = 1;
    step();

    // Small instance: DEPTH=1, CNT_W=4, 17 transfers wrap the counter to 1
    s_acc = 0; s_rel = 0;
    bus2.in_valid = 1; bus2.out_ready = 1; bus2.in_data = rnd128();
    for (int i = 0; i < 200 && s_rel < 17; i++) begin
      @(negedge clk);
      s_acc_now = bus2.in_valid && (q2.size() < 1);
      s_rel_now = (q2.size() != 0) && bus2.out_ready;
      chk("s_ready", bus2.in_ready, q2.size() < 1);
      if (s_rel_now) begin
        chk("s_data", bus2.out_data, q2[0]);
        void'(q2.pop_front());
        s_rel++;
      end
      if (s_acc_now) begin
        q2.push_back(inv_ref(bus2.in_data));
        s_acc++;
      end
      @(posedge clk); #1;
      if (s_acc_now) bus2.in_data = rnd128();
      bus2.in_valid = (s_acc < 17);
    end
    chk("s_rel17", s_rel, 17);
    chk("s_wrap", blk_cnt2, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
